mips_muldiv32: RTL and testbench

// Iterative multiply/divide unit in the EX stage, beside the 32-bit ALU.

---
 rtl/mips_muldiv32.sv | 170 +++++++++++++++++
 tb/tb_mips_muldiv32.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv32.sv
// mips_muldiv32 - iterative multiply/divide unit with architectural HI/LO.
//
// Executes MULT/MULTU/DIV/DIVU over WIDTH radix-2 steps, followed by one sign-fix
// cycle that writes HI/LO. It also services MTHI/MTLO in a single cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while idle
//   opr    in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   A      in   rs operand (dividend / multiplicand / MTHI-MTLO data)
//   B      in   rt operand (divisor / multiplier)
//   flush  in   abort the in-flight mul/div; HI/LO are left untouched
//   busy   out  mul/div in progress
//   done   out  one-cycle pulse when HI/LO were written by a mul/div
//   HI     out  upper product / remainder
//   LO     out  lower product / quotient
module mips_muldiv32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t             r_state;
    state_t             w_state_d;
    logic [CW-1:0]      r_cnt;
    // Multiply: {partial high, multiplier shifting out}. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_res;  // negate product / quotient
    logic               r_neg_rem;  // negate remainder (sign of dividend)
    logic               r_dz;       // divide by zero
    logic               r_done;

    logic               w_idle;
    logic               w_start_md;
    logic               w_start_mt;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [2*WIDTH:0]   w_div_sh;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_idle     = (r_state == StIdle);
    assign w_start_md = w_idle && start && !opr[2];
    assign w_start_mt = w_idle && start && opr[2] && !opr[1];
    // opr[0]==0 selects the signed variants.
    assign w_a_neg    = !opr[0] && A[WIDTH-1];
    assign w_b_neg    = !opr[0] && B[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -A : A;
    assign w_b_mag    = w_b_neg ? -B : B;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    // Shift-add: add multiplicand into the high half when the current multiplier
    // bit is set, then shift the whole accumulator right by one.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + ({1'b0, r_b} & {(WIDTH + 1){r_acc[0]}});
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring division: shift {rem, quo} left, trial-subtract the divisor.
    assign w_div_sh   = {r_acc, 1'b0};
    assign w_div_diff = w_div_sh[2*WIDTH:WIDTH] - {1'b0, r_b};
    assign w_div_step = w_div_diff[WIDTH] ? w_div_sh[2*WIDTH-1:0]
                                          : {w_div_diff[WIDTH-1:0], w_div_sh[WIDTH-1:1], 1'b1};

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    // Divide by zero leaves |A| as remainder, so the sign fix restores A itself.
    assign w_quo  = r_dz ? {WIDTH{1'b1}}
                         : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_start_md) w_state_d = StCalc;
            StCalc:  if (w_last) w_state_d = StFix;
            StFix:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if (flush && !w_idle) begin
            w_state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_done  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start_md) begin
                        r_acc     <= {{WIDTH{1'b0}}, (opr[1] ? w_a_mag : w_b_mag)};
                        r_b       <= opr[1] ? w_b_mag : w_a_mag;
                        r_is_div  <= opr[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dz      <= opr[1] && (B == '0);
                        r_cnt     <= '0;
                    end else if (w_start_mt) begin
                        if (opr[0]) begin
                            r_lo <= A;
                        end else begin
                            r_hi <= A;
                        end
                    end
                end
                StCalc: begin
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                StFix: begin
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = !w_idle;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_mips_muldiv32.sv
// Self-checking bench for mips_muldiv32: directed scenarios plus randomized
// operations, flushes, resets and ignored restarts checked against a reference model.
module tb_mips_muldiv32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  opr = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int vectors = 0;
    int miscompares = 0;

    // Architectural HI/LO as the reference model sees them.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mips_muldiv32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .opr   (opr),
        .A     (A),
        .B     (B),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: plain 64-bit arithmetic on the operands.
    function automatic void ref_md(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi,
                                   output logic [31:0] lo);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned p;
        longint unsigned ua;
        longint unsigned ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0;
        lo = '0;
        case (op)
            3'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            3'd2: begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFFFFFF;
                end else begin
                    q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
                end
            end
            3'd3: begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFFFFFF;
                end else begin
                    p = ua / ub; hi = 32'(ua % ub); lo = p[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        if ($urandom_range(0, 9) < 3) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issue one mul/div and observe 35 edges. flush_at/rst_at/restart_at give the
    // edge (relative to the start edge) at which that input is high; -1 = never.
    // flush_at==0 asserts flush together with start, while the unit is idle.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int rst_at, input int restart_at,
                          output int lat, output int ndone, output int busy_bad);
        bit aborted;
        bit exp_busy;
        lat = 0;
        ndone = 0;
        busy_bad = 0;
        aborted = 1'b0;
        @(negedge clk);
        start = 1'b1; opr = op; A = a; B = b; flush = (flush_at == 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0; A = $urandom; B = $urandom; opr = 3'($urandom_range(0, 7));
        if (busy !== 1'b1) busy_bad++;
        for (int e = 1; e <= 35; e++) begin
            rst = (e == rst_at);
            flush = (e == flush_at);
            if (e == restart_at) begin
                start = 1'b1; opr = 3'b001; A = 32'd9; B = 32'd9;
            end
            if (e == rst_at || e == flush_at) aborted = 1'b1;
            @(negedge clk);
            rst = 1'b0; flush = 1'b0; start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (lat == 0) lat = e;
            end
            exp_busy = (e <= 32) && !aborted;
            if (busy !== exp_busy) busy_bad++;
        end
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; opr = op; A = a;
        @(negedge clk);
        start = 1'b0; A = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        vectors++; if (HI !== 32'h0) begin miscompares++; $display("FAIL reset_hi got=%h exp=0", HI); end
        vectors++; if (LO !== 32'h0) begin miscompares++; $display("FAIL reset_lo got=%h exp=0", LO); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_mult();
        int lat, nd, bb;
        run_md(3'd0, 32'hFFFFFFFD, 32'd5, -1, -1, -1, lat, nd, bb);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL mult_latency got=%0d exp=33", lat); end
        vectors++; if (nd !== 1) begin miscompares++; $display("FAIL mult_done_pulses got=%0d exp=1", nd); end
        vectors++; if (bb !== 0) begin miscompares++; $display("FAIL mult_busy got=%0d bad cycles exp=0", bb); end
        vectors++; if (HI !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
        vectors++; if (LO !== 32'hFFFFFFF1) begin miscompares++; $display("FAIL mult_lo got=%h exp=fffffff1", LO); end
    endtask

    task automatic test_multu();
        int lat, nd, bb;
        run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, -1, lat, nd, bb);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL multu_latency got=%0d exp=33", lat); end
        vectors++; if (HI !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi got=%h exp=fffffffe", HI); end
        vectors++; if (LO !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo got=%h exp=00000001", LO); end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'd3, 3'd2, 3'd2, 3'd2};
        logic [31:0] as  [4] = '{32'd100, 32'hFFFFFFF9, 32'h80000000, 32'd1234};
        logic [31:0] bs  [4] = '{32'd7, 32'd2, 32'hFFFFFFFF, 32'd0};
        logic [31:0] his [4] = '{32'd2, 32'hFFFFFFFF, 32'h0, 32'd1234};
        logic [31:0] los [4] = '{32'd14, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        int lat, nd, bb;
        for (int i = 0; i < 4; i++) begin
            run_md(ops[i], as[i], bs[i], -1, -1, -1, lat, nd, bb);
            vectors++; if (lat !== 33 || nd !== 1) begin
                miscompares++; $display("FAIL div%0d_done lat=%0d pulses=%0d exp lat=33 pulses=1", i, lat, nd);
            end
            vectors++; if (HI !== his[i]) begin miscompares++; $display("FAIL div%0d_hi got=%h exp=%h", i, HI, his[i]); end
            vectors++; if (LO !== los[i]) begin miscompares++; $display("FAIL div%0d_lo got=%h exp=%h", i, LO, los[i]); end
        end
    endtask

    task automatic test_flush();
        int lat, nd, bb;
        run_mt(3'b100, 32'h0000AAAA);
        run_mt(3'b101, 32'h00005555);
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL mt_flags busy=%b done=%b exp 0/0", busy, done);
        end
        vectors++; if (HI !== 32'hAAAA || LO !== 32'h5555) begin
            miscompares++; $display("FAIL mt_regs got=%h/%h exp=0000aaaa/00005555", HI, LO);
        end
        run_md(3'd0, 32'd2, 32'd3, 10, -1, -1, lat, nd, bb);
        vectors++; if (nd !== 0) begin miscompares++; $display("FAIL flush_done got=%0d pulses exp=0", nd); end
        vectors++; if (bb !== 0) begin miscompares++; $display("FAIL flush_busy got=%0d bad cycles exp=0", bb); end
        vectors++; if (HI !== 32'hAAAA || LO !== 32'h5555) begin
            miscompares++; $display("FAIL flush_regs got=%h/%h exp=0000aaaa/00005555", HI, LO);
        end
        // Flush while idle is a no-op; the start in the same cycle still runs.
        run_md(3'd0, 32'd2, 32'd3, 0, -1, -1, lat, nd, bb);
        vectors++; if (lat !== 33 || nd !== 1) begin
            miscompares++; $display("FAIL idle_flush_done lat=%0d pulses=%0d exp 33/1", lat, nd);
        end
        vectors++; if (HI !== 32'h0 || LO !== 32'h6) begin
            miscompares++; $display("FAIL idle_flush_regs got=%h/%h exp=00000000/00000006", HI, LO);
        end
    endtask

    task automatic test_start_busy();
        int lat, nd, bb;
        run_md(3'd3, 32'd100, 32'd7, -1, -1, 5, lat, nd, bb);
        vectors++; if (lat !== 33 || nd !== 1 || bb !== 0) begin
            miscompares++; $display("FAIL restart_timing lat=%0d pulses=%0d busybad=%0d exp 33/1/0", lat, nd, bb);
        end
        vectors++; if (HI !== 32'd2 || LO !== 32'd14) begin
            miscompares++; $display("FAIL restart_regs got=%h/%h exp=00000002/0000000e", HI, LO);
        end
        m_hi = HI === 32'd2 ? 32'd2 : 32'd2;
        m_lo = 32'd14;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;
        int fa, ra, sa, r, lat, nd, bb, exp_nd;
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if (op[2]) begin
                run_mt(op, a);
                if (!op[1]) begin
                    if (op[0]) m_lo = a; else m_hi = a;
                end
                vectors++; if (busy !== 1'b0 || done !== 1'b0) begin
                    miscompares++; $display("FAIL rnd%0d_mt_flags op=%0d busy=%b done=%b", i, op, busy, done);
                end
            end else begin
                fa = -1; ra = -1; sa = -1;
                r = $urandom_range(0, 99);
                if (r < 15) fa = $urandom_range(1, 33);
                else if (r < 22) ra = $urandom_range(1, 33);
                else if (r < 35) sa = $urandom_range(1, 32);
                ref_md(op, a, b, eh, el);
                run_md(op, a, b, fa, ra, sa, lat, nd, bb);
                exp_nd = (fa < 0 && ra < 0) ? 1 : 0;
                if (ra >= 0) begin
                    m_hi = '0; m_lo = '0;
                end else if (fa < 0) begin
                    m_hi = eh; m_lo = el;
                end
                vectors++; if (nd !== exp_nd || (exp_nd == 1 && lat !== 33)) begin
                    miscompares++;
                    $display("FAIL rnd%0d_done op=%0d pulses=%0d lat=%0d exp pulses=%0d", i, op, nd, lat, exp_nd);
                end
                vectors++; if (bb !== 0) begin
                    miscompares++; $display("FAIL rnd%0d_busy op=%0d bad cycles=%0d exp=0", i, op, bb);
                end
            end
            vectors++; if (HI !== m_hi || LO !== m_lo) begin
                miscompares++;
                $display("FAIL rnd%0d_regs op=%0d a=%h b=%h got=%h/%h exp=%h/%h",
                         i, op, a, b, HI, LO, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_flush();
        test_start_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
